// File: rtl/alu_sequencer.sv
// Control-side sequencer for an external combinational ALU.
// It decodes handshaked instructions, drives the ALU operands, captures the result, and writes it back to a small register file.
module alu_sequencer #(
  parameter int DATA_W = 8,
  parameter int NREG   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_fs,
  input  logic [DATA_W-1:0] alu_c,
  input  logic [7:0]        alu_flag,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic [7:0]        flags
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_CAPT,
    S_RETIRE
  } state_t;

  localparam logic [1:0] K_ALU_RR = 2'b00;
  localparam logic [1:0] K_LOADI  = 2'b01;
  localparam logic [1:0] K_ALU_RI = 2'b10;
  localparam logic [1:0] K_READ   = 2'b11;
  localparam logic [1:0] FS_CMP   = 2'b01;

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_regs [NREG];
  logic [1:0]        r_kind;
  logic [1:0]        r_rd;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_c;
  logic [7:0]        r_flag;

  logic              w_accept;
  logic [1:0]        w_kind;
  logic [1:0]        w_fs;
  logic [1:0]        w_rd;
  logic [1:0]        w_rs;
  logic [1:0]        w_rt;
  logic [7:0]        w_imm;

  assign w_kind   = instr[15:14];
  assign w_fs     = instr[13:12];
  assign w_rd     = instr[11:10];
  assign w_rs     = instr[9:8];
  assign w_rt     = instr[1:0];
  assign w_imm    = instr[7:0];
  assign w_accept = instr_valid && (r_state == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    instr_ready = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (w_accept) w_next = w_kind[0] ? S_RETIRE : S_EXEC;
      end
      S_EXEC:   w_next = S_CAPT;
      S_CAPT:   w_next = S_RETIRE;
      S_RETIRE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // Operands are read at accept time, so a RETIRE write never races a same-register read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_fs  <= '0;
      rd_data <= '0;
      flags   <= '0;
      r_kind  <= '0;
      r_rd    <= '0;
      r_imm   <= '0;
      r_c     <= '0;
      r_flag  <= '0;
    end else begin
      if (w_accept) begin
        r_kind <= w_kind;
        r_rd   <= w_rd;
        r_imm  <= DATA_W'(w_imm);
        if (!w_kind[0]) begin
          alu_a  <= r_regs[w_rs];
          alu_b  <= (w_kind == K_ALU_RR) ? r_regs[w_rt] : DATA_W'(w_imm);
          alu_fs <= w_fs;
        end
        if (w_kind == K_READ) rd_data <= r_regs[w_rs];
      end
      if (r_state == S_CAPT) begin
        r_c    <= alu_c;
        r_flag <= alu_flag;
      end
      // CMP only updates flags; its ALU result is meaningless and must not reach the register file.
      if (r_state == S_RETIRE) begin
        case (r_kind)
          K_ALU_RR, K_ALU_RI: begin
            flags <= r_flag;
            if (alu_fs != FS_CMP) r_regs[r_rd] <= r_c;
          end
          K_LOADI: r_regs[r_rd] <= r_imm;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural ALU and an instruction-level reference model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        instrValid;
  logic        instrReady;
  logic [7:0]  aluA;
  logic [7:0]  aluB;
  logic [1:0]  aluFs;
  logic [7:0]  aluC;
  logic [7:0]  aluFlag;
  logic        done;
  logic [7:0]  rdData;
  logic [7:0]  flags;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mReg [4];
  logic [7:0] mFlags;
  logic [7:0] mRdData;
  logic [7:0] mA;
  logic [7:0] mB;
  logic [1:0] mFs;

  alu_sequencer #(.DATA_W(8), .NREG(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instrValid),
    .instr_ready(instrReady), .alu_a(aluA), .alu_b(aluB), .alu_fs(aluFs),
    .alu_c(aluC), .alu_flag(aluFlag), .done(done), .rd_data(rdData), .flags(flags)
  );

  always #5 clk = ~clk;

  // External ALU: ADD/CMP/SUB/INC; CMP drives a deliberately non-trivial C that must be ignored.
  function automatic logic [15:0] aluFn(input logic [7:0] a, input logic [7:0] b, input logic [1:0] fs);
    logic [8:0] s;
    logic [7:0] c;
    logic [7:0] fl;
    fl = 8'h00;
    case (fs)
      2'b00: begin s = {1'b0, a} + {1'b0, b}; c = s[7:0]; fl[0] = s[8]; end
      2'b01: begin c = a ^ b ^ 8'h5A; fl[3] = (a > b); end
      2'b10: begin c = a - b; fl[3] = (a < b); end
      default: begin s = {1'b0, a} + 9'd1; c = s[7:0]; fl[3] = s[8]; end
    endcase
    fl[1] = (c == 8'h00);
    fl[7] = c[7];
    return {c, fl};
  endfunction

  assign {aluC, aluFlag} = aluFn(aluA, aluB, aluFs);

  function automatic logic [15:0] enc(input logic [1:0] k, input logic [1:0] fs, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [7:0] imm);
    return {k, fs, rd, rs, imm};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 4; i++) mReg[i] = 8'h00;
    mFlags = 8'h00; mRdData = 8'h00; mA = 8'h00; mB = 8'h00; mFs = 2'b00;
  endtask

  task automatic modelExec(input logic [15:0] w, output int lat);
    logic [15:0] r;
    logic [7:0]  b;
    if (w[15:14] == 2'b01) begin
      mReg[w[11:10]] = w[7:0];
      lat = 1;
    end else if (w[15:14] == 2'b11) begin
      mRdData = mReg[w[9:8]];
      lat = 1;
    end else begin
      b = (w[15:14] == 2'b00) ? mReg[w[1:0]] : w[7:0];
      mA = mReg[w[9:8]]; mB = b; mFs = w[13:12];
      r = aluFn(mA, mB, mFs);
      if (mFs != 2'b01) mReg[w[11:10]] = r[15:8];
      mFlags = r[7:0];
      lat = 3;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkArch(input string tag);
    checkOutput({tag, "_flags"}, 16'(flags), 16'(mFlags));
    checkOutput({tag, "_rd_data"}, 16'(rdData), 16'(mRdData));
    checkOutput({tag, "_alu_a"}, 16'(aluA), 16'(mA));
    checkOutput({tag, "_alu_b"}, 16'(aluB), 16'(mB));
    checkOutput({tag, "_alu_fs"}, 16'(aluFs), 16'(mFs));
  endtask

  // Issue one instruction from IDLE and return in IDLE one cycle after its done pulse.
  task automatic applyStimulus(input logic [15:0] w, input string tag);
    int expLat;
    int lat;
    modelExec(w, expLat);
    checkOutput({tag, "_ready_idle"}, 16'(instrReady), 16'd1);
    instr = w; instrValid = 1'b1;
    @(posedge clk); #1;
    instrValid = 1'b0;
    lat = 1;
    while (!done && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, "_latency"}, 16'(lat), 16'(expLat));
    checkOutput({tag, "_ready_busy"}, 16'(instrReady), 16'd0);
    @(posedge clk); #1;
    checkOutput({tag, "_done_pulse"}, 16'(done), 16'd0);
    checkArch(tag);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] w;
    rst = 1'b1; instr = 16'h0000; instrValid = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state and READs of a cleared register file
    checkOutput("rst_done", 16'(done), 16'd0);
    checkOutput("rst_ready", 16'(instrReady), 16'd1);
    checkArch("rst");
    for (int i = 0; i < 4; i++) applyStimulus(enc(2'b11, 2'b00, 2'b00, 2'(i), 8'h00), "read_rst");

    // LOADI + ADD with carry out
    applyStimulus(enc(2'b01, 2'b00, 2'd1, 2'd0, 8'hF0), "loadi_r1");
    applyStimulus(enc(2'b01, 2'b00, 2'd2, 2'd0, 8'h20), "loadi_r2");
    applyStimulus(enc(2'b00, 2'b00, 2'd3, 2'd1, 8'h02), "add_r3");
    checkOutput("add_carry_flag", 16'(flags[0]), 16'd1);
    applyStimulus(enc(2'b11, 2'b00, 2'd0, 2'd3, 8'h00), "read_r3");
    checkOutput("add_r3_value", 16'(rdData), 16'h0010);

    // CMP sets flags only
    applyStimulus(enc(2'b00, 2'b01, 2'd1, 2'd1, 8'h02), "cmp_r1_r2");
    checkOutput("cmp_flag3", 16'(flags[3]), 16'd1);
    applyStimulus(enc(2'b11, 2'b00, 2'd0, 2'd1, 8'h00), "read_r1");
    checkOutput("cmp_r1_unchanged", 16'(rdData), 16'h00F0);

    // INC wraps 0xFF with carry
    applyStimulus(enc(2'b01, 2'b00, 2'd0, 2'd0, 8'hFF), "loadi_r0");
    applyStimulus(enc(2'b10, 2'b11, 2'd0, 2'd0, 8'h00), "inc_r0");
    checkOutput("inc_flag3", 16'(flags[3]), 16'd1);
    applyStimulus(enc(2'b11, 2'b00, 2'd0, 2'd0, 8'h00), "read_r0");
    checkOutput("inc_r0_value", 16'(rdData), 16'h0000);

    // Three back-to-back ADDs r3 = r3 + r1 with instr_valid held high
    w = enc(2'b00, 2'b00, 2'd3, 2'd3, 8'h01);
    begin
      int dummy;
      int doneCount;
      for (int k = 0; k < 3; k++) modelExec(w, dummy);
      doneCount = 0;
      instr = w; instrValid = 1'b1;
      checkOutput("b2b_ready_t0", 16'(instrReady), 16'd1);
      for (int t = 1; t <= 14; t++) begin
        @(posedge clk); #1;
        if (t == 9) instrValid = 1'b0;
        if (done) doneCount++;
        checkOutput($sformatf("b2b_ready_t%0d", t), 16'(instrReady), 16'((t % 4 == 0) || (t >= 12)));
        checkOutput($sformatf("b2b_done_t%0d", t), 16'(done), 16'((t % 4 == 3) && (t <= 11)));
      end
      checkOutput("b2b_done_count", 16'(doneCount), 16'd3);
      checkOutput("b2b_flags", 16'(flags), 16'(mFlags));
      applyStimulus(enc(2'b11, 2'b00, 2'd0, 2'd3, 8'h00), "b2b_read_r3");
    end

    // Reset during CAPT of an ADD to r2 aborts it
    instr = enc(2'b00, 2'b00, 2'd2, 2'd1, 8'h01); instrValid = 1'b1;
    @(posedge clk); #1;
    instrValid = 1'b0;
    checkOutput("abort_exec_done", 16'(done), 16'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    modelReset();
    checkOutput("abort_done", 16'(done), 16'd0);
    checkOutput("abort_ready", 16'(instrReady), 16'd1);
    checkArch("abort");
    @(posedge clk); #1;
    checkOutput("abort_no_late_done", 16'(done), 16'd0);
    applyStimulus(enc(2'b11, 2'b00, 2'd0, 2'd2, 8'h00), "abort_read_r2");
    checkOutput("abort_r2_zero", 16'(rdData), 16'h0000);

    // Randomized instruction stream against the reference model
    for (int n = 0; n < 60; n++) applyStimulus(16'($urandom), "rand");
    for (int i = 0; i < 4; i++) applyStimulus(enc(2'b11, 2'b00, 2'b00, 2'(i), 8'h00), "final_read");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
